rr_hold_arbiter: RTL and testbench

- Parametrised round-robin arbiter for the pixel-array row/column event readout. It is the successor to the fixed-priority grant logic.
- Registered one-hot grant is held until the winner acknowledges. The priority pointer then rotates past the winner so no requester starves.
- Sits between the pixel row/column request lines and the event readout/serialiser; one instance per axis.

---
 rtl/lib_arbiter_pkg.sv | 21 ++
 rtl/rr_mask_pick.sv | 54 +++++
 rtl/rr_hold_arbiter.sv | 149 ++++++++++++++
 tb/tb_rr_hold_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lib_arbiter_pkg.sv
// ============================================================================
// Module      : lib_arbiter_pkg
// Description : Shared types and defaults for the readout arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lib_arbiter_pkg;

    localparam int ROWS            = 16;
    localparam int ARB_N_REQ_DEF   = ROWS;
    localparam int ARB_TIMEOUT_DEF = 255;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_mask_pick.sv
// ============================================================================
// Module      : rr_mask_pick
// Description : Combinational round-robin pick: lowest active request at or
//               above ptr_i, else lowest active request overall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mask_pick #(
    parameter int N_REQ = 16,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_any;
    logic             lo_any;

    // Scanning downward means the last hit written is the lowest index.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = IDX_W'(i);
                lo_any = 1'b1;
                if (i >= int'(ptr_i)) begin
                    hi_idx = IDX_W'(i);
                    hi_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pick_o = '0;
        idx_o  = hi_any ? hi_idx : lo_idx;
        any_o  = lo_any;
        if (lo_any) begin
            pick_o[idx_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_hold_arbiter.sv
// ============================================================================
// Module      : rr_hold_arbiter
// Description : Round-robin arbiter with grant held until acknowledge.
//               Optional forced release enabled by macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_hold_arbiter
    import lib_arbiter_pkg::*;
#(
    parameter int N_REQ       = ARB_N_REQ_DEF,
    parameter int IDX_W       = $clog2(N_REQ),
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             ack_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             to_q, to_d;

    logic             ack_fire;
    logic             to_fire;
    logic             release_grant;
    logic             load_grant;
    logic [IDX_W-1:0] ptr_adv;
    logic [IDX_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign ack_fire      = (state_q == ARB_GRANT) && ack_i;
    assign release_grant = ack_fire || to_fire;
    assign ptr_adv       = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    // On release the re-pick already sees the advanced pointer, so the
    // served requester drops to lowest priority without an idle bubble.
    assign pick_ptr      = release_grant ? ptr_adv : ptr_q;

    rr_mask_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (pick_ptr),
        .pick_o (pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        to_d       = 1'b0;
        load_grant = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (en_i && pick_any) begin
                    state_d    = ARB_GRANT;
                    gnt_d      = pick_oh;
                    idx_d      = pick_idx;
                    load_grant = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (release_grant) begin
                    ptr_d = ptr_adv;
                    to_d  = to_fire && !ack_i;
                    if (en_i && pick_any) begin
                        gnt_d      = pick_oh;
                        idx_d      = pick_idx;
                        load_grant = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign to_fire = (state_q == ARB_GRANT) && !ack_i
                     && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_grant) begin
            cnt_d = '0;
        end else if ((state_q == ARB_GRANT) && !ack_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = (state_q == ARB_GRANT);
    assign timeout_o   = to_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_hold_arbiter.sv
// ============================================================================
// Module      : tb_rr_hold_arbiter
// Description : Directed vector bench for rr_hold_arbiter (N_REQ=4, TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_hold_arbiter;

    localparam int N_REQ       = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int NV          = 25;

    logic       clk_i;
    logic       rst_n_i;
    logic       en_i;
    logic [3:0] req_i;
    logic       ack_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_idx_o;
    logic       gnt_valid_o;
    logic       timeout_o;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       ack;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
    } vec_t;

    vec_t vecs [NV];

    rr_hold_arbiter #(
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .req_i       (req_i),
        .ack_i       (ack_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .timeout_o   (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(input string nm, input logic [3:0] g, input logic [1:0] ix,
                             input logic v, input logic t);
        check({nm, ".gnt"}, 32'(gnt_o), 32'(g));
        check({nm, ".idx"}, 32'(gnt_idx_o), 32'(ix));
        check({nm, ".valid"}, 32'(gnt_valid_o), 32'(v));
        check({nm, ".timeout"}, 32'(timeout_o), 32'(t));
    endtask

    task automatic do_reset();
        #2;
        rst_n_i = 1'b0;
        en_i    = 1'b0;
        req_i   = 4'b0000;
        ack_i   = 1'b0;
        step();
        #2;
        rst_n_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //              en    req      ack   gnt      idx   vld
        vecs[0]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[1]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[3]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[4]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[5]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        vecs[7]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
        vecs[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        vecs[11] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
        vecs[12] = '{1'b1, 4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[13] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1};
        vecs[14] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0};
        vecs[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0};
        vecs[16] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd3, 1'b0};
        vecs[17] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd3, 1'b0};
        vecs[18] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[19] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[20] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[21] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0};
        vecs[22] = '{1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[23] = '{1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[24] = '{1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1};

        rst_n_i = 1'b0;
        en_i    = 1'b0;
        req_i   = 4'b0000;
        ack_i   = 1'b0;
        #12;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            en_i  = vecs[i].en;
            req_i = vecs[i].req;
            ack_i = vecs[i].ack;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld, 1'b0);
        end

        // Move the grant to idx 2 (ptr=1 after last ack), then reset mid-grant.
        en_i  = 1'b1;
        req_i = 4'b0100;
        ack_i = 1'b1;
        step();
        check_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
        ack_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        #2;
        rst_n_i = 1'b1;
        req_i   = 4'b1100;
        step();
        check_out("post_rst", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Full rotation from a fresh pointer.
        do_reset();
        en_i  = 1'b1;
        req_i = 4'b1111;
        step();
        check_out("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);
        ack_i = 1'b1;
        step();
        check_out("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step();
        check_out("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        check_out("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        check_out("rot4", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Unacknowledged grant on idx 1 with idx 2 also waiting.
        do_reset();
        en_i  = 1'b1;
        req_i = 4'b0010;
        step();
        check_out("hold0", 4'b0010, 2'd1, 1'b1, 1'b0);
        req_i = 4'b0110;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            step();
            check_out($sformatf("hold%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step();
        check_out("to_fire", 4'b0100, 2'd2, 1'b1, 1'b1);
        step();
        check_out("to_after", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            check_out($sformatf("hold%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
